// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and sizing helpers for the slice-serial add/sub sequencer
package addsub_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // At least one bit, since the slice count is always two or more
  function automatic int calc_idx_w(input int width, input int slice);
    return $clog2(width / slice);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// rtl/cla_slice.sv - combinational SLICE-bit adder built from 4-bit lookahead carry groups
module cla_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  localparam int NG = SLICE / 4;

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE-1:0] cv;
  logic             cc;

  assign g = a & b;
  assign p = a ^ b;

  // Carries are looked ahead inside each 4-bit group; group carries ripple between groups
  always_comb begin
    cv = '0;
    cc = cin;
    for (int k = 0; k < NG; k++) begin
      cv[4*k]   = cc;
      cv[4*k+1] = g[4*k] | (p[4*k] & cc);
      cv[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cc);
      cv[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                | (p[4*k+2] & p[4*k+1] & p[4*k] & cc);
      cc        = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & cc);
    end
    sum  = p ^ cv;
    cout = cc;
    cmsb = cv[SLICE-1];
  end

endmodule

// File: rtl/addsub_sequencer.sv
// rtl/addsub_sequencer.sv - slice-serial WIDTH-bit add/subtract controller; ADDSEQ_ABORT_EN adds an abort input
module addsub_sequencer
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDSEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NSLICE = calc_nslice(WIDTH, SLICE);
  localparam int IW     = calc_idx_w(WIDTH, SLICE);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] res_full;
  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic [SLICE-1:0] ssum;
  logic             scout;
  logic             scmsb;
  logic             last;
  logic             accept;
  logic             abort_hit;

`ifdef ADDSEQ_ABORT_EN
  assign abort_hit = (state == RUN) && abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign last   = (idx == IW'(NSLICE - 1));
  assign accept = start && (state != RUN);
  assign sa     = opa[idx*SLICE +: SLICE];
  assign sb     = opb[idx*SLICE +: SLICE];

  cla_slice #(.SLICE(SLICE)) u_slice (
    .a    (sa),
    .b    (sb),
    .cin  (carry),
    .sum  (ssum),
    .cout (scout),
    .cmsb (scmsb)
  );

  always_comb begin
    res_full = result;
    res_full[idx*SLICE +: SLICE] = ssum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN: begin
        if (abort_hit) state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready = (state != RUN);
    busy  = (state == RUN);
    done  = (state == DONE);
  end

  // B is stored pre-inverted so the slice adder never needs to know the operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa      <= '0;
      opb      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (abort_hit) begin
      idx      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      opa      <= a;
      opb      <= op_sub ? ~b : b;
      carry    <= cin;
      idx      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (state == RUN) begin
      result <= res_full;
      carry  <= scout;
      idx    <= last ? '0 : idx + 1'b1;
      if (last) begin
        cout     <= scout;
        overflow <= scmsb ^ scout;
        zero     <= (res_full == '0);
      end
    end
  end

endmodule

// File: tb/tb_addsub_sequencer.sv
// tb/tb_addsub_sequencer.sv - randomized self-checking bench for addsub_sequencer
module tb_addsub_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op_sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cout;
  logic        overflow;
  logic        zero;
`ifdef ADDSEQ_ABORT_EN
  logic        abort;
`endif

  int tests = 0;
  int fails = 0;

  addsub_sequencer #(.WIDTH(32), .SLICE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef ADDSEQ_ABORT_EN
    .abort    (abort),
`endif
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic ref_op(input logic [31:0] x, input logic [31:0] y, input logic s, input logic c,
                        output logic [31:0] r, output logic co, output logic ov, output logic z);
    logic [32:0] t;
    logic [31:0] yy;
    yy = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + {32'd0, c};
    r  = t[31:0];
    co = t[32];
    ov = (x[31] == yy[31]) && (r[31] != x[31]);
    z  = (r == 32'd0);
  endtask

  // Drives one request and reports what the DUT produced; latency counts negedges after the accept edge
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s, input logic c,
                        output int lat, output logic [31:0] r, output logic co, output logic ov,
                        output logic z, output logic done_after, output logic [31:0] r_after);
    @(negedge clk);
    a = x; b = y; op_sub = s; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = result; co = cout; ov = overflow; z = zero;
    @(negedge clk);
    done_after = done;
    r_after    = result;
  endtask

  task automatic test_reset();
    logic [37:0] got;
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef ADDSEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    got = {ready, busy, done, cout, overflow, zero, result};
    tests++;
    if (got !== {1'b1, 5'b0, 32'd0}) begin
      fails++;
      $display("FAIL reset_state: got %h expected %h", got, {1'b1, 5'b0, 32'd0});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    logic        c;
    logic [31:0] r;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  task automatic test_directed();
    vec_t v[3];
    int lat;
    logic [31:0] r, ra;
    logic co, ov, z, da;
    v[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
    v[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    v[2] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_op(v[i].x, v[i].y, v[i].s, v[i].c, lat, r, co, ov, z, da, ra);
      tests++;
      if (lat != 5) begin
        fails++;
        $display("FAIL directed%0d_latency: got %0d expected 5", i, lat);
      end
      tests++;
      if ({r, co, ov, z} !== {v[i].r, v[i].co, v[i].ov, v[i].z}) begin
        fails++;
        $display("FAIL directed%0d_result: got r=%h co=%b ov=%b z=%b expected r=%h co=%b ov=%b z=%b",
                 i, r, co, ov, z, v[i].r, v[i].co, v[i].ov, v[i].z);
      end
      tests++;
      if (da !== 1'b0 || ra !== v[i].r) begin
        fails++;
        $display("FAIL directed%0d_hold: got done=%b r=%h expected done=0 r=%h", i, da, ra, v[i].r);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] x, y, r, ra, er;
    logic s, c, co, ov, z, da, eco, eov, ez;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: x = 32'hFFFFFFFF;
        1: x = 32'h80000000 ^ 32'($urandom_range(0, 3));
        default: x = $urandom;
      endcase
      y = ($urandom_range(0, 4) == 0) ? x : $urandom;
      s = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      ref_op(x, y, s, c, er, eco, eov, ez);
      run_op(x, y, s, c, lat, r, co, ov, z, da, ra);
      tests++;
      if (lat != 5) begin
        fails++;
        $display("FAIL random%0d_latency: got %0d expected 5", i, lat);
      end
      tests++;
      if ({r, co, ov, z} !== {er, eco, eov, ez}) begin
        fails++;
        $display("FAIL random%0d_result a=%h b=%h sub=%b cin=%b: got r=%h co=%b ov=%b z=%b expected r=%h co=%b ov=%b z=%b",
                 i, x, y, s, c, r, co, ov, z, er, eco, eov, ez);
      end
      tests++;
      if (da !== 1'b0) begin
        fails++;
        $display("FAIL random%0d_done_pulse: got done=%b expected 0 one cycle after done", i, da);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a = 32'h00000010; b = 32'h00000020; op_sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 32'hDEADBEEF; b = 32'h12345678; op_sub = 1'b1; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_early_done: got done=%b expected 0", done);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || result !== 32'h00000030) begin
      fails++;
      $display("FAIL b2b_first: got done=%b r=%h expected done=1 r=00000030", done, result);
    end
    a = 32'h00000007; b = 32'h00000003; op_sub = 1'b1; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (done !== 1'b0 || busy !== 1'b1 || result !== 32'd0) begin
      fails++;
      $display("FAIL b2b_accept: got done=%b busy=%b r=%h expected done=0 busy=1 r=00000000", done, busy, result);
    end
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if (lat != 5) begin
      fails++;
      $display("FAIL b2b_second_latency: got %0d expected 5", lat);
    end
    tests++;
    if (result !== 32'h00000004 || cout !== 1'b1 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second_result: got r=%h co=%b ov=%b expected r=00000004 co=1 ov=0", result, cout, overflow);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] r, ra;
    logic co, ov, z, da;
    logic [37:0] got;
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; op_sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = {ready, busy, done, cout, overflow, zero, result};
    tests++;
    if (got !== {1'b1, 5'b0, 32'd0}) begin
      fails++;
      $display("FAIL reset_mid_outputs: got %h expected %h", got, {1'b1, 5'b0, 32'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, lat, r, co, ov, z, da, ra);
    tests++;
    if (lat != 5 || r !== 32'h23456789 || co !== 1'b0 || ov !== 1'b0 || z !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_next_op: got lat=%0d r=%h co=%b ov=%b z=%b expected lat=5 r=23456789 co=0 ov=0 z=0",
               lat, r, co, ov, z);
    end
  endtask

`ifdef ADDSEQ_ABORT_EN
  task automatic test_abort();
    int lat, seen;
    logic [31:0] r, ra, er, x, y;
    logic co, ov, z, da, eco, eov, ez;
    logic [37:0] got;
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'h00000000; op_sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1; start = 1'b1; a = 32'h1; b = 32'h1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    got = {ready, busy, done, cout, overflow, zero, result};
    tests++;
    if (got !== {1'b1, 5'b0, 32'd0}) begin
      fails++;
      $display("FAIL abort_idle: got %h expected %h", got, {1'b1, 5'b0, 32'd0});
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL abort_no_done: got %0d active cycles expected 0", seen);
    end
    x = $urandom; y = $urandom;
    ref_op(x, y, 1'b1, 1'b1, er, eco, eov, ez);
    run_op(x, y, 1'b1, 1'b1, lat, r, co, ov, z, da, ra);
    tests++;
    if (lat != 5 || {r, co, ov, z} !== {er, eco, eov, ez}) begin
      fails++;
      $display("FAIL abort_next_op: got lat=%0d r=%h co=%b ov=%b z=%b expected lat=5 r=%h co=%b ov=%b z=%b",
               lat, r, co, ov, z, er, eco, eov, ez);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
`ifdef ADDSEQ_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
